// File: rtl/uaz8_pkg.sv
// Shared definitions for the MicroUAZ8 fetch path: FSM encoding, default
// address width / reset PC, and the fetch buffer depth.
// Optional feature macro: FETCH_PREFETCH_EN (two-entry prefetch buffer).
package uaz8_pkg;

  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned RESET_PC_DEF = 0;

  // Fetch FSM encoding
  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

`ifdef FETCH_PREFETCH_EN
  // Two slots let a fetch overlap a decode stall and stream at 1 byte/cycle.
  localparam int unsigned FETCH_DEPTH = 2;
`else
  // Single slot: fetch waits for each byte to be consumed.
  localparam int unsigned FETCH_DEPTH = 1;
`endif

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of {opcode, address} entries between fetch and decode.
// Flush wins over push/pop. Storage is not cleared on flush, so the head
// stays stable (stale) while the buffer is empty.
module fetch_buf #(
  parameter int unsigned      DEPTH   = 1,
  parameter int unsigned      W       = 16,
  parameter logic [W-1:0]     RST_VAL = '0
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_Push,
  input  logic         i_Pop,
  input  logic         i_Flush,
  input  logic [W-1:0] i_Data,
  output logic [W-1:0] o_Head,
  output logic         o_Full,
  output logic         o_Empty,
  output logic         o_Last_Slot
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_Full      = (cnt_q == CW'(DEPTH));
  assign o_Empty     = (cnt_q == '0);
  assign o_Last_Slot = (cnt_q == CW'(DEPTH - 1));
  assign o_Head      = mem_q[rd_q];

  // A push into a full buffer is only legal when the head leaves this cycle.
  assign pop_ok  = i_Pop  & ~i_Flush & ~o_Empty;
  assign push_ok = i_Push & ~i_Flush & (~o_Full | pop_ok);

  // Pointer and occupancy next-state
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (i_Flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = ptr_inc(wr_q);
      if (pop_ok)  rd_d = ptr_inc(rd_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; reset value defines the head seen before any fetch
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= RST_VAL;
    end else if (push_ok) begin
      mem_q[wr_q] <= i_Data;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// MicroUAZ8 instruction fetch sequencer: walks the program counter, reads
// opcode bytes over a req/ack handshake, buffers them and hands them to
// decode over valid/ready. Jumps flush the buffer; an in-flight read is
// always completed (and discarded) before the new target is requested.
// Optional feature macro: FETCH_PREFETCH_EN (see uaz8_pkg).
module instr_fetch
  import uaz8_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  output logic              o_Mem_Req,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  input  logic              i_Mem_Ack,
  input  logic [7:0]        i_Mem_Data,
  input  logic              i_Jump,
  input  logic [ADDR_W-1:0] i_Jump_Addr,
  output logic [7:0]        o_Instruction,
  output logic [ADDR_W-1:0] o_PC,
  output logic              o_Valid,
  input  logic              i_Ready
);

  localparam int unsigned EW = 8 + ADDR_W;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              started_q;

  logic              ack_acc, pop, push, flush;
  logic              buf_full, buf_empty, buf_last;
  logic              full_after;
  logic [EW-1:0]     head;

  // started_q keeps the request low during and right after reset even
  // though the FSM already sits in S_REQ.
  assign o_Mem_Req  = started_q & (state_q != S_IDLE);
  assign o_Mem_Addr = fpc_q;
  assign ack_acc    = o_Mem_Req & i_Mem_Ack;

  assign o_Valid    = ~buf_empty;
  assign pop        = o_Valid & i_Ready & ~i_Jump;
  // Occupancy after this cycle's push and pop, given that a push happens.
  assign full_after = pop ? buf_full : buf_last;

  assign o_Instruction = head[EW-1:ADDR_W];
  assign o_PC          = head[ADDR_W-1:0];

  // Fetch FSM, fetch pointer and jump-target next-state
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    tgt_d   = tgt_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (!started_q) begin
      // No request has been issued yet, so a jump simply retargets.
      if (i_Jump) begin
        flush = 1'b1;
        fpc_d = i_Jump_Addr;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (i_Jump) begin
            flush = 1'b1;
            if (ack_acc) begin
              fpc_d = i_Jump_Addr;
            end else begin
              tgt_d   = i_Jump_Addr;
              state_d = S_DRAIN;
            end
          end else if (ack_acc) begin
            push  = 1'b1;
            fpc_d = fpc_q + ADDR_W'(1);
            if (full_after) state_d = S_IDLE;
          end
        end
        S_IDLE: begin
          if (i_Jump) begin
            flush   = 1'b1;
            fpc_d   = i_Jump_Addr;
            state_d = S_REQ;
          end else if (pop) begin
            state_d = S_REQ;
          end
        end
        S_DRAIN: begin
          if (i_Jump) begin
            flush = 1'b1;
            tgt_d = i_Jump_Addr;
          end
          // Drained data is dropped; the newest target always wins.
          if (ack_acc) begin
            fpc_d   = i_Jump ? i_Jump_Addr : tgt_q;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // Fetch state registers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= S_REQ;
      fpc_q     <= RESET_PC;
      tgt_q     <= RESET_PC;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      tgt_q     <= tgt_d;
      started_q <= 1'b1;
    end
  end

  fetch_buf #(
    .DEPTH   (FETCH_DEPTH),
    .W       (EW),
    .RST_VAL ({8'h00, RESET_PC})
  ) u_buf (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .i_Push      (push),
    .i_Pop       (pop),
    .i_Flush     (flush),
    .i_Data      ({i_Mem_Data, fpc_q}),
    .o_Head      (head),
    .o_Full      (buf_full),
    .o_Empty     (buf_empty),
    .o_Last_Slot (buf_last)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: a behavioural memory responder plus directed
// and randomized scenarios. The reference model only knows that decode must
// see consecutive program addresses carrying mem[pc], restarting at the
// jump target after every jump.
module tb_instr_fetch;
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_req, mem_ack, jump, valid, ready;
  logic [7:0] mem_addr, mem_data, jaddr, instr, pc;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [256];
  int         wait_cfg = 1;
  bit         spur_en = 1'b0;
  bit         busy = 1'b0;
  int         waits = 0;
  logic [7:0] held = 8'h00;
  int         proto_err = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .o_Mem_Req     (mem_req),
    .o_Mem_Addr    (mem_addr),
    .i_Mem_Ack     (mem_ack),
    .i_Mem_Data    (mem_data),
    .i_Jump        (jump),
    .i_Jump_Addr   (jaddr),
    .o_Instruction (instr),
    .o_PC          (pc),
    .o_Valid       (valid),
    .i_Ready       (ready)
  );

  // Memory responder: wait_cfg wait cycles per request (-1 = random 0..2),
  // flags address changes or dropped requests mid-handshake.
  initial begin
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 1'b0;
        busy    = 1'b0;
      end else if (mem_req) begin
        if (!busy) begin
          busy  = 1'b1;
          held  = mem_addr;
          waits = (wait_cfg < 0) ? int'($urandom_range(2, 0)) : wait_cfg;
        end else if (mem_addr !== held) begin
          proto_err++;
        end
        if (waits == 0) begin
          mem_ack  = 1'b1;
          mem_data = mem[mem_addr];
          busy     = 1'b0;
        end else begin
          mem_ack  = 1'b0;
          mem_data = 8'($urandom);
          waits--;
        end
      end else begin
        if (busy) proto_err++;
        busy     = 1'b0;
        mem_ack  = spur_en && ($urandom_range(3, 0) == 0);
        mem_data = 8'($urandom);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    jump  = 1'b0;
    jaddr = 8'h00;
    ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    jump = 1'b0; jaddr = 8'h00; ready = 1'b0;
    repeat (2) tick();
    tests++; if (mem_req !== 1'b0)  begin fails++; $display("FAIL rst_req: got %b want 0", mem_req); end
    tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL rst_addr: got %h want 00", mem_addr); end
    tests++; if (valid !== 1'b0)    begin fails++; $display("FAIL rst_valid: got %b want 0", valid); end
    tests++; if (instr !== 8'h00)   begin fails++; $display("FAIL rst_instr: got %h want 00", instr); end
    tests++; if (pc !== 8'h00)      begin fails++; $display("FAIL rst_pc: got %h want 00", pc); end
    rst_n = 1'b1;
    tick();
    tests++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      fails++; $display("FAIL rst_first_req: got req=%b addr=%h want req=1 addr=00", mem_req, mem_addr);
    end
  endtask

  task automatic test_basic();
    logic [7:0] req_q[$], pc_q[$], op_q[$];
    logic [7:0] exp_op[3];
    logic       last_req = 1'b0;
    logic [7:0] last_addr = 8'h00;
    mem[0] = 8'h01; mem[1] = 8'h0B; mem[2] = 8'hFF;
    exp_op[0] = 8'h01; exp_op[1] = 8'h0B; exp_op[2] = 8'hFF;
    wait_cfg = 1; spur_en = 1'b0;
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (mem_req && (!last_req || mem_addr != last_addr)) req_q.push_back(mem_addr);
      last_req = mem_req; last_addr = mem_addr;
      if (valid && ready) begin pc_q.push_back(pc); op_q.push_back(instr); end
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= req_q.size()) begin fails++; $display("FAIL basic_req%0d: missing want %0d", i, i); end
      else if (req_q[i] !== 8'(i)) begin fails++; $display("FAIL basic_req%0d: got %h want %h", i, req_q[i], 8'(i)); end
      tests++;
      if (i >= pc_q.size()) begin fails++; $display("FAIL basic_xfer%0d: missing", i); end
      else if (pc_q[i] !== 8'(i) || op_q[i] !== exp_op[i]) begin
        fails++; $display("FAIL basic_xfer%0d: got %h@%h want %h@%h", i, op_q[i], pc_q[i], exp_op[i], 8'(i));
      end
    end
  endtask

  task automatic test_stream();
    int n = 0, nv = 0, run = 0, maxrun = 0, pc_err = 0;
    logic [7:0] exp;
    wait_cfg = 0; spur_en = 1'b0;
    do_reset();
    ready = 1'b1;
    tick();
    while (!valid && n < 10) begin tick(); n++; end
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL stream_start: got valid=%b want 1", valid); end
    exp = pc;
    for (int i = 0; i < 16; i++) begin
      if (valid) begin
        nv++; run++;
        if (pc !== exp || instr !== mem[exp]) pc_err++;
        exp = exp + 8'd1;
      end else run = 0;
      if (run > maxrun) maxrun = run;
      tick();
    end
    tests++; if (nv != ((DEPTH == 2) ? 16 : 8)) begin fails++; $display("FAIL stream_count: got %0d want %0d", nv, (DEPTH == 2) ? 16 : 8); end
    tests++; if (maxrun != ((DEPTH == 2) ? 16 : 1)) begin fails++; $display("FAIL stream_run: got %0d want %0d", maxrun, (DEPTH == 2) ? 16 : 1); end
    tests++; if (pc_err != 0) begin fails++; $display("FAIL stream_data: got %0d bad want 0", pc_err); end
  endtask

  task automatic test_stall();
    logic [7:0] exp = 8'h00;
    int got = 0;
    wait_cfg = 0; spur_en = 1'b1;
    do_reset();
    repeat (12) tick();
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL stall_req: got %b want 0", mem_req); end
    tests++; if (valid !== 1'b1 || pc !== 8'h00) begin fails++; $display("FAIL stall_head: got v=%b pc=%h want v=1 pc=00", valid, pc); end
    ready = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (c == 1) begin
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 8'(DEPTH)) begin
          fails++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, 8'(DEPTH));
        end
      end
      if (valid && ready) begin
        tests++;
        if (pc !== exp || instr !== mem[exp]) begin
          fails++; $display("FAIL stall_xfer: got %h@%h want %h@%h", instr, pc, mem[exp], exp);
        end
        exp = exp + 8'd1; got++;
      end
      tick();
    end
    tests++; if (got != 6) begin fails++; $display("FAIL stall_count: got %0d want 6", got); end
    spur_en = 1'b0;
  endtask

  task automatic test_jump();
    int n = 0;
    bit held_ok = 1'b1;
    wait_cfg = 2; spur_en = 1'b0;
    do_reset();
    ready = 1'b1;
    tick();
    while (!(mem_req && mem_addr == 8'h05 && !mem_ack) && n < 200) begin tick(); n++; end
    tests++; if (!(mem_req && mem_addr == 8'h05)) begin fails++; $display("FAIL jump_setup: got addr=%h want 05", mem_addr); end
    jump = 1'b1; jaddr = 8'h40;
    tick();
    jump = 1'b0;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL jump_flush: got valid=%b want 0", valid); end
    n = 0;
    while (!(mem_req && mem_ack) && n < 10) begin
      if (mem_addr !== 8'h05 || !mem_req) held_ok = 1'b0;
      tick(); n++;
    end
    if (mem_addr !== 8'h05) held_ok = 1'b0;
    tests++; if (held_ok !== 1'b1) begin fails++; $display("FAIL jump_hold: got addr=%h want 05 held", mem_addr); end
    tick();
    tests++; if (mem_req !== 1'b1 || mem_addr !== 8'h40) begin fails++; $display("FAIL jump_newreq: got req=%b addr=%h want 1/40", mem_req, mem_addr); end
    n = 0;
    while (!valid && n < 10) begin tick(); n++; end
    tests++; if (valid !== 1'b1 || pc !== 8'h40 || instr !== mem[8'h40]) begin
      fails++; $display("FAIL jump_xfer: got v=%b %h@%h want %h@40", valid, instr, pc, mem[8'h40]);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] req_q[$], pc_q[$], op_q[$];
    logic [7:0] exp_a[3];
    logic       last_req = 1'b1;
    logic [7:0] last_addr = 8'h00;
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
    wait_cfg = 1; spur_en = 1'b0;
    do_reset();
    ready = 1'b1;
    tick();
    jump = 1'b1; jaddr = 8'hFE;
    tick();
    jump = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (mem_req && (!last_req || mem_addr != last_addr)) req_q.push_back(mem_addr);
      last_req = mem_req; last_addr = mem_addr;
      if (valid && ready) begin pc_q.push_back(pc); op_q.push_back(instr); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= req_q.size() || req_q[i] !== exp_a[i]) begin
        fails++; $display("FAIL wrap_req%0d: got %h want %h", i, (i < req_q.size()) ? req_q[i] : 8'hxx, exp_a[i]);
      end
      tests++;
      if (i >= pc_q.size() || pc_q[i] !== exp_a[i] || op_q[i] !== mem[exp_a[i]]) begin
        fails++; $display("FAIL wrap_xfer%0d: got pc %h want %h@%h", i, (i < pc_q.size()) ? pc_q[i] : 8'hxx, mem[exp_a[i]], exp_a[i]);
      end
    end
  endtask

  task automatic test_reset_drain();
    int n = 0;
    mem[0] = 8'hA5;
    wait_cfg = 3; spur_en = 1'b0;
    do_reset();
    tick();
    while (!valid && n < 20) begin tick(); n++; end
    n = 0;
    while (!(mem_req && !mem_ack) && n < 20) begin
      jump = !mem_req; jaddr = 8'h33;
      tick(); n++;
    end
    jump = 1'b1; jaddr = 8'h44;
    tick();
    jump = 1'b0;
    tests++; if (mem_req !== 1'b1 || mem_addr === 8'h00 || mem_addr === 8'h44) begin
      fails++; $display("FAIL drain_setup: got req=%b addr=%h want req=1 old addr", mem_req, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || mem_addr !== 8'h00) begin fails++; $display("FAIL drain_rst_mem: got req=%b addr=%h want 0/00", mem_req, mem_addr); end
    tests++; if (valid !== 1'b0 || pc !== 8'h00 || instr !== 8'h00) begin
      fails++; $display("FAIL drain_rst_out: got v=%b %h@%h want 0 00@00", valid, instr, pc);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tests++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin fails++; $display("FAIL drain_restart: got req=%b addr=%h want 1/00", mem_req, mem_addr); end
    ready = 1'b1;
    n = 0;
    while (!valid && n < 10) begin tick(); n++; end
    tests++; if (valid !== 1'b1 || pc !== 8'h00 || instr !== 8'hA5) begin
      fails++; $display("FAIL drain_xfer: got v=%b %h@%h want a5@00", valid, instr, pc);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_pc = 8'h00;
    bit         jumped = 1'b0;
    int         nx = 0;
    wait_cfg = -1; spur_en = 1'b1; proto_err = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      tick();
      if (jumped) begin
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL rand_flush: cycle %0d got valid=%b want 0", c, valid); end
      end
      ready = ($urandom_range(9, 0) < 7);
      jump  = ($urandom_range(39, 0) == 0);
      jaddr = 8'($urandom);
      if (jump) begin
        exp_pc = jaddr; jumped = 1'b1;
      end else begin
        jumped = 1'b0;
        if (valid && ready) begin
          tests++;
          if (pc !== exp_pc || instr !== mem[exp_pc]) begin
            fails++; $display("FAIL rand_xfer: cycle %0d got %h@%h want %h@%h", c, instr, pc, mem[exp_pc], exp_pc);
          end
          exp_pc = exp_pc + 8'd1; nx++;
        end
      end
    end
    jump = 1'b0;
    tests++; if (nx < 50) begin fails++; $display("FAIL rand_progress: got %0d transfers want >=50", nx); end
    tests++; if (proto_err != 0) begin fails++; $display("FAIL rand_protocol: got %0d errors want 0", proto_err); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    jump = 1'b0; jaddr = 8'h00; ready = 1'b0;
    test_reset();
    test_basic();
    test_stream();
    test_stall();
    test_jump();
    test_wrap();
    test_reset_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer for the 8-bit MicroUAZ8 core. It reads opcode bytes from program memory over a request/acknowledge handshake and keeps a program counter. It buffers fetched bytes and presents them, with their addresses, to the decode stage, which includes immediate extraction, over a valid/ready handshake. It is the producer side of the `i_Instruction` bus that the decode logic consumes.

## Interface
- `ADDR_W`, 8, program-memory address width; PC wraps modulo 2^ADDR_W.
- `RESET_PC`, 0, address of the first fetch after reset.

- `i_Clk`  in  1  single clock; all state updates on its rising edge.
- `i_Rst_n`  in  1  reset, asynchronous, active-low.
- `o_Mem_Req`  out  1  memory read request.
- `o_Mem_Addr`  out  ADDR_W  read address; stable while `o_Mem_Req` is high.
- `i_Mem_Ack`  in  1  read complete; `i_Mem_Data` is valid in the same cycle.
- `i_Mem_Data`  in  8  opcode byte returned by memory.
- `i_Jump`  in  1  one-cycle pulse that redirects fetch.
- `i_Jump_Addr`  in  ADDR_W  jump target, sampled when `i_Jump` is high.
- `o_Instruction`  out  8  head-of-buffer opcode, meaning the `i_Instruction` seen by decode.
- `o_PC`  out  ADDR_W  address of `o_Instruction`.
- `o_Valid`  out  1  head entry is valid.
- `i_Ready`  in  1  decode accepts the head; a transfer occurs when `o_Valid & i_Ready`.

## Operation
- Fetch pointer `FPC` resets to `RESET_PC`. It increments by 1 on each accepted, non-discarded `i_Mem_Ack` and wraps from 2^ADDR_W−1 to 0.
- The buffer is a FIFO of {opcode, address} entries. Its depth is `DEPTH`, set by the Configuration macro.
  - Push happens on an accepted ack.
  - Pop happens on a transfer.
  - Push and pop in the same cycle are both performed.
- FSM states and transitions:
  - `S_REQ`: `o_Mem_Req`=1 and `o_Mem_Addr`=`FPC`.
    - On ack: push, `FPC`++.
    - After the ack, if the buffer would be full following this cycle's push and pop, go to `S_IDLE`; otherwise stay in `S_REQ` with the new address.
  - `S_IDLE`: `o_Mem_Req`=0. Go to `S_REQ` in the cycle after a pop frees a slot.
  - `S_DRAIN`: `o_Mem_Req`=1 with the old address held. The returning ack is discarded (no push). Then go to `S_REQ` with `FPC` = latched target.
- Jump (`i_Jump`=1):
  - The buffer is flushed, so `o_Valid` is 0 the next cycle. A transfer in the same cycle is ignored.
  - If `S_REQ` with no ack this cycle: go to `S_DRAIN`, latch the target. The handshake is never aborted.
  - If `S_REQ` with ack this cycle, or `S_IDLE`: `FPC` ← `i_Jump_Addr`, go to `S_REQ`. The acked data is discarded.
  - If `S_DRAIN`: the latched target is overwritten with the new `i_Jump_Addr`.
- `i_Mem_Ack` while `o_Mem_Req`=0 is ignored.

## Timing
- Reset values:
  - `o_Mem_Req`=0, `o_Mem_Addr`=`RESET_PC`.
  - `o_Valid`=0, `o_Instruction`=8'h00, `o_PC`=`RESET_PC`.
  - FSM in `S_REQ`; the first request is visible in the first cycle after `i_Rst_n` deasserts.
- Ack to `o_Valid`: 1 cycle, because the data is registered on the ack edge.
- Request to request: if the buffer has space, `o_Mem_Req` stays high and `o_Mem_Addr` advances in the cycle after an ack. A zero-wait memory (ack in every request cycle) therefore sustains 1 byte per cycle when `DEPTH`=2 and `i_Ready`=1.
- Jump to first new-target request: 1 cycle from `S_REQ`-with-ack or `S_IDLE`; 1 cycle after the draining ack from `S_DRAIN`.
- Reset asserted mid-handshake clears all state immediately; an outstanding memory cycle is abandoned.
- `o_Instruction` and `o_PC` are undefined-but-stable (last head) while `o_Valid`=0.

## Configuration
- `FETCH_PREFETCH_EN` defined: `DEPTH`=2. Fetch overlaps decode stalls and back-to-back streaming is possible.
- Not defined: `DEPTH`=1. After each ack the FSM goes to `S_IDLE` unless a pop occurs in the same cycle, which limits throughput to at most 1 byte per 2 cycles.

## Structure
- Shared package `uaz8_pkg`:
  - FSM state encoding (`S_REQ`, `S_IDLE`, `S_DRAIN`).
  - Default `ADDR_W`.
  - `RESET_PC`.
- One sub-module, `fetch_buf`: the parameterised FIFO of {opcode, address}, with push, pop, flush, and full/empty flags. The FSM and `FPC` stay in `instr_fetch`.

## Test plan
- Reset release, memory acks each request after 1 wait cycle returning 8'h01, 8'h0B, 8'hFF, `i_Ready`=1 → addresses 0,1,2 requested; decode receives 8'h01@PC0, 8'h0B@PC1, 8'hFF@PC2 in order.
- Zero-wait memory with `FETCH_PREFETCH_EN` and `i_Ready`=1 → one transfer per cycle, no bubbles. Without the macro → `o_Valid` is high at most every other cycle.
- Hold `i_Ready`=0 → `o_Mem_Req` drops once the buffer holds `DEPTH` entries. Raise `i_Ready` → request resumes 1 cycle after the first pop and no byte is lost.
- `i_Jump` with `i_Jump_Addr`=8'h40 while a request to 8'h05 is pending → 8'h05 stays on the bus until ack, its data is discarded, and the next request is 8'h40; the next transfer is @PC 8'h40.
- `ADDR_W`=8, start fetch at 8'hFE → addresses 8'hFE, 8'hFF, 8'h00, with `o_PC` wrapping accordingly.
- Assert `i_Rst_n`=0 mid-`S_DRAIN` → all outputs return to reset values asynchronously; fetch restarts at `RESET_PC` after release.
